// File: rtl/kgp_risc_pkg.sv
// Shared kgp_risc definitions: select encodings used by the routing blocks.
package kgp_risc_pkg;

    // Destination select for demux_1to3_buffered; 2'b11 aliases channel A.
    typedef enum logic [1:0] {
        SEL_A     = 2'b00,
        SEL_B     = 2'b01,
        SEL_C     = 2'b10,
        SEL_A_ALT = 2'b11
    } demux_sel_e;

endpackage

// File: rtl/demux_1to3_buffered_if.sv
// Input word/select handshake plus three buffered output channels.
interface demux_1to3_buffered_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_sel;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_a_data;
    logic              out_a_valid;
    logic              out_a_ready;
    logic [DATA_W-1:0] out_b_data;
    logic              out_b_valid;
    logic              out_b_ready;
    logic [DATA_W-1:0] out_c_data;
    logic              out_c_valid;
    logic              out_c_ready;

    modport master (
        output in_data, in_sel, in_valid,
        input  in_ready,
        input  out_a_data, out_a_valid, out_b_data, out_b_valid, out_c_data, out_c_valid,
        output out_a_ready, out_b_ready, out_c_ready
    );

    modport slave (
        input  in_data, in_sel, in_valid,
        output in_ready,
        output out_a_data, out_a_valid, out_b_data, out_b_valid, out_c_data, out_c_valid,
        input  out_a_ready, out_b_ready, out_c_ready
    );
endinterface

// File: rtl/demux_1to3_buffered_sync_fifo.sv
// Single-clock FIFO; head reads zero when empty, push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/demux_1to3_buffered.sv
// Routes each accepted input word into one of three buffered FIFO channels by in_sel.
module demux_1to3_buffered
    import kgp_risc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input logic                  clk,
    input logic                  rst,
    demux_1to3_buffered_if.slave bus
);
    demux_sel_e w_sel;
    logic       w_ready;
    logic       w_push_a, w_push_b, w_push_c;
    logic       w_full_a, w_full_b, w_full_c;
    logic       w_empty_a, w_empty_b, w_empty_c;

    assign w_sel = demux_sel_e'(bus.in_sel);

    // Ready depends only on the addressed queue's full flag, never on in_valid or a same-cycle pop.
    always_comb begin
        w_ready  = 1'b0;
        w_push_a = 1'b0;
        w_push_b = 1'b0;
        w_push_c = 1'b0;
        case (w_sel)
            SEL_A, SEL_A_ALT: begin
                w_ready  = !w_full_a;
                w_push_a = bus.in_valid && !w_full_a;
            end
            SEL_B: begin
                w_ready  = !w_full_b;
                w_push_b = bus.in_valid && !w_full_b;
            end
            SEL_C: begin
                w_ready  = !w_full_c;
                w_push_c = bus.in_valid && !w_full_c;
            end
            default: ;
        endcase
    end

    assign bus.in_ready    = w_ready;
    assign bus.out_a_valid = !w_empty_a;
    assign bus.out_b_valid = !w_empty_b;
    assign bus.out_c_valid = !w_empty_c;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst(rst), .i_push(w_push_a), .i_pop(bus.out_a_ready), .i_wdata(bus.in_data),
        .o_full(w_full_a), .o_empty(w_empty_a), .o_head(bus.out_a_data)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst(rst), .i_push(w_push_b), .i_pop(bus.out_b_ready), .i_wdata(bus.in_data),
        .o_full(w_full_b), .o_empty(w_empty_b), .o_head(bus.out_b_data)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_c (
        .clk(clk), .rst(rst), .i_push(w_push_c), .i_pop(bus.out_c_ready), .i_wdata(bus.in_data),
        .o_full(w_full_c), .o_empty(w_empty_c), .o_head(bus.out_c_data)
    );
endmodule

// File: tb/tb_demux_1to3_buffered.sv
// Directed vector table, hand-written corner sequences and a scoreboarded random run.
module tb_demux_1to3_buffered;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    demux_1to3_buffered_if #(.DATA_W(DW)) bus ();

    demux_1to3_buffered #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        vld;
        logic [2:0]  rdy;      // {c, b, a}
        logic        exp_rdy;
        logic [2:0]  exp_vld;  // {c, b, a}
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_c;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mkv(logic [31:0] d, logic [1:0] s, logic v, logic [2:0] r,
                                 logic er, logic [2:0] ev, logic [31:0] ea,
                                 logic [31:0] eb, logic [31:0] ec);
        vec_t t;
        t.data = d; t.sel = s; t.vld = v; t.rdy = r;
        t.exp_rdy = er; t.exp_vld = ev; t.exp_a = ea; t.exp_b = eb; t.exp_c = ec;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [2:0] r);
        bus.in_data     = d;
        bus.in_sel      = s;
        bus.in_valid    = v;
        bus.out_a_ready = r[0];
        bus.out_b_ready = r[1];
        bus.out_c_ready = r[2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] ev,
                              input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
        check({tag, " a_valid"}, 32'(bus.out_a_valid), 32'(ev[0]));
        check({tag, " b_valid"}, 32'(bus.out_b_valid), 32'(ev[1]));
        check({tag, " c_valid"}, 32'(bus.out_c_valid), 32'(ev[2]));
        check({tag, " a_data"}, bus.out_a_data, ea);
        check({tag, " b_data"}, bus.out_b_data, eb);
        check({tag, " c_data"}, bus.out_c_data, ec);
    endtask

    logic [31:0] qa[$], qb[$], qc[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mkv(32'h11111111, 2'b00, 1, 3'b111, 1, 3'b001, 32'h11111111, 0, 0);
        vecs[1]  = mkv(32'h0,        2'b00, 0, 3'b111, 1, 3'b000, 0, 0, 0);
        vecs[2]  = mkv(32'hA0,       2'b01, 1, 3'b000, 1, 3'b010, 0, 32'hA0, 0);
        vecs[3]  = mkv(32'hA1,       2'b01, 1, 3'b000, 1, 3'b010, 0, 32'hA0, 0);
        vecs[4]  = mkv(32'hFF,       2'b01, 1, 3'b000, 0, 3'b010, 0, 32'hA0, 0);
        vecs[5]  = mkv(32'h0,        2'b10, 0, 3'b000, 1, 3'b010, 0, 32'hA0, 0);
        vecs[6]  = mkv(32'h0,        2'b01, 0, 3'b010, 0, 3'b010, 0, 32'hA1, 0);
        vecs[7]  = mkv(32'h0,        2'b00, 0, 3'b010, 1, 3'b000, 0, 0, 0);
        vecs[8]  = mkv(32'h5,        2'b11, 1, 3'b000, 1, 3'b001, 32'h5, 0, 0);
        vecs[9]  = mkv(32'h0,        2'b00, 0, 3'b001, 1, 3'b000, 0, 0, 0);
        vecs[10] = mkv(32'hC0,       2'b10, 1, 3'b000, 1, 3'b100, 0, 0, 32'hC0);
        vecs[11] = mkv(32'hC1,       2'b10, 1, 3'b100, 1, 3'b100, 0, 0, 32'hC1);
        vecs[12] = mkv(32'h0,        2'b10, 0, 3'b100, 1, 3'b000, 0, 0, 0);

        drive('0, 2'b00, 0, 3'b000);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_outs("reset", 3'b000, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].data, vecs[i].sel, vecs[i].vld, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c);
        end

        // Full B with a concurrent pop: push must be refused, then accepted next cycle.
        drive(32'hB0, 2'b01, 1, 3'b000); step();
        drive(32'hB1, 2'b01, 1, 3'b000); step();
        drive(32'hB2, 2'b01, 1, 3'b010);
        #1;
        check("fullpop in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check_outs("fullpop", 3'b010, 0, 32'hB1, 0);
        drive(32'hB2, 2'b01, 1, 3'b000);
        #1;
        check("retry in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_outs("retry", 3'b010, 0, 32'hB1, 0);
        drive(32'h0, 2'b00, 0, 3'b010); step();
        check_outs("drain1", 3'b010, 0, 32'hB2, 0);
        step();
        check_outs("drain2", 3'b000, 0, 0, 0);

        // Random stalls with interleaved destinations A,B,C,A.
        begin
            int unsigned k = 0;
            logic [1:0]  pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
            for (int cyc = 0; cyc < 1000; cyc++) begin
                logic        v;
                logic [2:0]  r;
                logic [1:0]  s;
                logic [31:0] d;
                int          tsz;
                v = ($urandom_range(0, 3) != 0);
                r = 3'($urandom_range(0, 7));
                s = pat[k % 4];
                d = (k << 4) | ((k % 4) + 1);
                drive(d, s, v, r);
                #1;
                tsz = (s == 2'b01) ? qb.size() : (s == 2'b10) ? qc.size() : qa.size();
                check("rand in_ready", 32'(bus.in_ready), 32'(tsz < DEPTH));
                check_outs("rand", {qc.size() != 0, qb.size() != 0, qa.size() != 0},
                           (qa.size() != 0) ? qa[0] : 32'h0,
                           (qb.size() != 0) ? qb[0] : 32'h0,
                           (qc.size() != 0) ? qc[0] : 32'h0);
                if (r[0] && qa.size() != 0) void'(qa.pop_front());
                if (r[1] && qb.size() != 0) void'(qb.pop_front());
                if (r[2] && qc.size() != 0) void'(qc.pop_front());
                if (v && tsz < DEPTH) begin
                    if (s == 2'b01)      qb.push_back(d);
                    else if (s == 2'b10) qc.push_back(d);
                    else                 qa.push_back(d);
                    k++;
                end
                step();
            end
        end

        // Mid-operation reset discards everything asynchronously.
        drive(32'h0, 2'b00, 0, 3'b111); step(); step(); step();
        drive(32'hD0, 2'b00, 1, 3'b000); step();
        drive(32'hD1, 2'b01, 1, 3'b000); step();
        drive(32'hD2, 2'b10, 1, 3'b000); step();
        drive(32'h0, 2'b00, 0, 3'b000);
        #1;
        check_outs("prereset", 3'b111, 32'hD0, 32'hD1, 32'hD2);
        rst = 1'b1;
        #1;
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        check_outs("midrst", 3'b000, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(32'h77, 2'b01, 1, 3'b000);
        step();
        drive(32'h0, 2'b00, 0, 3'b000);
        check_outs("postrst", 3'b010, 0, 32'h77, 0);
        drive(32'h0, 2'b00, 0, 3'b111);
        step();
        check_outs("postrst drain", 3'b000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
